// File: rtl/c5g_housekeeping_ext_int_cond_if.sv
// Control/status bundle between the external-interrupt conditioner and the
// housekeeping side (PIO in_port and the firmware control pulses).
//   irq_en, clr_capture, clr_count : from housekeeping to the conditioner
//   int_level_n, fall_pulse, capture, irq, event_count : conditioner status
interface c5g_housekeeping_ext_int_cond_if #(
   parameter int unsigned CNT_W = 8
);
   logic             irq_en;
   logic             clr_capture;
   logic             clr_count;
   logic             int_level_n;
   logic             fall_pulse;
   logic             capture;
   logic             irq;
   logic [CNT_W-1:0] event_count;

   // Housekeeping side: drives controls, observes status
   modport master (
      output irq_en, clr_capture, clr_count,
      input  int_level_n, fall_pulse, capture, irq, event_count
   );

   // Conditioner side
   modport slave (
      input  irq_en, clr_capture, clr_count,
      output int_level_n, fall_pulse, capture, irq, event_count
   );
endinterface

// File: rtl/c5g_housekeeping_ext_int_cond.sv
// External interrupt pin conditioner for the housekeeping PIO.
// Synchronises the raw active-low pin (two flops), debounces it with a
// programmable stable-cycle count, and reports the clean level, a one-cycle
// falling-edge pulse, a sticky capture flag with maskable irq and a
// saturating count of accepted falling edges.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   ext_int_n_pin  : raw asynchronous pin, active low
//   bus (slave)    : irq_en/clr_capture/clr_count in;
//                    int_level_n/fall_pulse/capture/irq/event_count out
module c5g_housekeeping_ext_int_cond #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 ext_int_n_pin,
   c5g_housekeeping_ext_int_cond_if.slave       bus
);

   localparam int unsigned      DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             s1_q, s2_q;
   logic             level_n_q, level_n_d;
   logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic             fall_pulse_q, fall_pulse_d;
   logic             capture_q, capture_d;
   logic             irq_q, irq_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Synchroniser: metastability is confined to s1, nothing between s1 and s2
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= ext_int_n_pin;
         s2_q <= s1_q;
      end
   end

   // Debounce, edge detect, capture, irq and event counter next-state
   always_comb begin
      level_n_d    = level_n_q;
      db_cnt_d     = '0;
      fall_pulse_d = 1'b0;
      capture_d    = capture_q;
      irq_d        = capture_q & bus.irq_en;
      count_d      = count_q;

      // Any cycle matching the accepted level restarts the stable count
      if (s2_q != level_n_q) begin
         if (db_cnt_q == DB_LAST) begin
            level_n_d    = s2_q;
            // Accepting a 0 means the level went 1->0
            fall_pulse_d = ~s2_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end

      // Set has priority over clear
      if (bus.clr_capture) capture_d = 1'b0;
      if (fall_pulse_q)    capture_d = 1'b1;

      // Clear coincident with an event keeps the event
      if (fall_pulse_q && (count_q != CNT_MAX)) count_d = count_q + CNT_W'(1);
      if (bus.clr_count) count_d = fall_pulse_q ? CNT_W'(1) : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_n_q    <= 1'b1;
         db_cnt_q     <= '0;
         fall_pulse_q <= 1'b0;
         capture_q    <= 1'b0;
         irq_q        <= 1'b0;
         count_q      <= '0;
      end else begin
         level_n_q    <= level_n_d;
         db_cnt_q     <= db_cnt_d;
         fall_pulse_q <= fall_pulse_d;
         capture_q    <= capture_d;
         irq_q        <= irq_d;
         count_q      <= count_d;
      end
   end

   assign bus.int_level_n = level_n_q;
   assign bus.fall_pulse  = fall_pulse_q;
   assign bus.capture     = capture_q;
   assign bus.irq         = irq_q;
   assign bus.event_count = count_q;

endmodule

// File: tb/tb_c5g_housekeeping_ext_int_cond.sv
// Directed bench for the external interrupt conditioner. Instance u_dut0 uses
// DEBOUNCE_CYCLES=4/CNT_W=8; u_dut1 uses DEBOUNCE_CYCLES=1 for the rising
// acceptance case. Expected fall_pulse cycles are queued when the pin is
// driven and popped by a negedge monitor when the pulse appears.
module tb_c5g_housekeeping_ext_int_cond;

   localparam int unsigned LAT0 = 2 + 4;   // pin change to fall_pulse, D=4

   logic clk = 1'b0;
   logic reset_n;
   logic pin0;
   logic pin1;

   int cyc       = 0;
   int n_checks  = 0;
   int n_errors  = 0;
   int exp_count = 0;
   int e;
   int pulse_q[$];

   c5g_housekeeping_ext_int_cond_if #(.CNT_W(8)) bus0 ();
   c5g_housekeeping_ext_int_cond_if #(.CNT_W(8)) bus1 ();

   c5g_housekeeping_ext_int_cond #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) u_dut0 (
      .clk           (clk),
      .reset_n       (reset_n),
      .ext_int_n_pin (pin0),
      .bus           (bus0)
   );

   c5g_housekeeping_ext_int_cond #(.DEBOUNCE_CYCLES(1), .CNT_W(8)) u_dut1 (
      .clk           (clk),
      .reset_n       (reset_n),
      .ext_int_n_pin (pin1),
      .bus           (bus1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One clean falling acceptance followed by a clean rising acceptance
   task automatic do_fall();
      int t;
      t = cyc;
      pin0 = 1'b0;
      pulse_q.push_back(t + int'(LAT0));
      step(7);
      pin0 = 1'b1;
      step(7);
      if (exp_count < 255) exp_count++;
   endtask

   // Scoreboard: every fall_pulse must match the front of the queue in time
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus0.fall_pulse) begin
            n_checks++;
            assert (pulse_q.size() != 0) else begin
               n_errors++;
               $error("FAIL unexpected_pulse: observed pulse at cycle %0d expected none", cyc);
            end
            if (pulse_q.size() != 0) check("pulse_cycle", 32'(cyc), 32'(pulse_q.pop_front()));
         end else if (pulse_q.size() != 0 && pulse_q[0] < cyc) begin
            check("missing_pulse", 32'(bus0.fall_pulse), 32'd1);
            void'(pulse_q.pop_front());
         end
      end
   end

   initial begin
      reset_n          = 1'b0;
      pin0             = 1'b0;
      pin1             = 1'b0;
      bus0.irq_en      = 1'b1;
      bus0.clr_capture = 1'b0;
      bus0.clr_count   = 1'b0;
      bus1.irq_en      = 1'b0;
      bus1.clr_capture = 1'b0;
      bus1.clr_count   = 1'b0;

      // Reset values with the pin held low
      step(3);
      check("rst_level",   32'(bus0.int_level_n), 32'd1);
      check("rst_fall",    32'(bus0.fall_pulse),  32'd0);
      check("rst_capture", 32'(bus0.capture),     32'd0);
      check("rst_irq",     32'(bus0.irq),         32'd0);
      check("rst_count",   32'(bus0.event_count), 32'd0);

      // Pin low through reset release is accepted after normal latency
      e = cyc;
      reset_n = 1'b1;
      pulse_q.push_back(e + int'(LAT0));
      step(5);
      check("rel_level_e5", 32'(bus0.int_level_n), 32'd1);
      step(1);
      check("rel_level_e6", 32'(bus0.int_level_n), 32'd0);
      check("rel_fall_e6",  32'(bus0.fall_pulse),  32'd1);
      step(1);
      check("rel_capture_e7", 32'(bus0.capture),     32'd1);
      check("rel_count_e7",   32'(bus0.event_count), 32'd1);
      check("rel_fall_e7",    32'(bus0.fall_pulse),  32'd0);
      check("rel_irq_e7",     32'(bus0.irq),         32'd0);
      step(1);
      check("rel_irq_e8", 32'(bus0.irq), 32'd1);
      check("d1_level_low",   32'(bus1.int_level_n), 32'd0);
      check("d1_capture_set", 32'(bus1.capture),     32'd1);

      // Return high and clear everything
      pin0 = 1'b1;
      step(12);
      check("high_level", 32'(bus0.int_level_n), 32'd1);
      bus0.clr_capture = 1'b1;
      bus0.clr_count   = 1'b1;
      step(1);
      bus0.clr_capture = 1'b0;
      bus0.clr_count   = 1'b0;
      exp_count = 0;
      check("clr_capture", 32'(bus0.capture),     32'd0);
      check("clr_count",   32'(bus0.event_count), 32'(exp_count));
      step(1);
      check("clr_irq", 32'(bus0.irq), 32'd0);
      bus0.irq_en = 1'b0;

      // Glitch of 3 cycles is rejected
      pin0 = 1'b0;
      step(3);
      pin0 = 1'b1;
      step(12);
      check("glitch_level", 32'(bus0.int_level_n), 32'd1);
      check("glitch_count", 32'(bus0.event_count), 32'(exp_count));

      // 4-cycle low is accepted
      e = cyc;
      pin0 = 1'b0;
      pulse_q.push_back(e + int'(LAT0));
      step(4);
      pin0 = 1'b1;
      step(2);
      check("low4_level", 32'(bus0.int_level_n), 32'd0);
      step(12);
      exp_count++;
      check("low4_count", 32'(bus0.event_count), 32'(exp_count));
      check("low4_back_high", 32'(bus0.int_level_n), 32'd1);

      // Chatter: only the final stable low produces a pulse
      repeat (10) begin
         pin0 = 1'b0;
         step(3);
         pin0 = 1'b1;
         step(1);
      end
      e = cyc;
      pin0 = 1'b0;
      pulse_q.push_back(e + int'(LAT0));
      step(20);
      exp_count++;
      check("chatter_count", 32'(bus0.event_count), 32'(exp_count));
      pin0 = 1'b1;
      step(12);

      // Capture with irq masked, then unmask
      check("mask_irq_idle", 32'(bus0.irq), 32'd0);
      bus0.clr_capture = 1'b1;
      step(1);
      bus0.clr_capture = 1'b0;
      check("mask_cleared", 32'(bus0.capture), 32'd0);
      e = cyc;
      pin0 = 1'b0;
      pulse_q.push_back(e + int'(LAT0));
      step(8);
      exp_count++;
      check("mask_capture", 32'(bus0.capture), 32'd1);
      check("mask_irq",     32'(bus0.irq),     32'd0);
      bus0.irq_en = 1'b1;
      step(1);
      check("unmask_irq", 32'(bus0.irq), 32'd1);
      pin0 = 1'b1;
      step(12);
      bus0.clr_capture = 1'b1;
      step(1);
      bus0.clr_capture = 1'b0;
      check("clr_alone_capture", 32'(bus0.capture), 32'd0);
      step(1);
      check("clr_alone_irq", 32'(bus0.irq), 32'd0);

      // clr_capture coincident with a fall_pulse: set wins
      e = cyc;
      pin0 = 1'b0;
      pulse_q.push_back(e + int'(LAT0));
      step(6);
      check("coinc_fall", 32'(bus0.fall_pulse), 32'd1);
      bus0.clr_capture = 1'b1;
      step(1);
      bus0.clr_capture = 1'b0;
      exp_count++;
      check("coinc_capture", 32'(bus0.capture),     32'd1);
      check("coinc_count",   32'(bus0.event_count), 32'(exp_count));
      pin0 = 1'b1;
      step(12);

      // Saturation after 260 clean falls
      for (int i = 0; i < 260; i++) begin
         do_fall();
         if (i == 100) check("sat_mid_count", 32'(bus0.event_count), 32'(exp_count));
      end
      check("sat_count", 32'(bus0.event_count), 32'(exp_count));
      check("sat_value", 32'(bus0.event_count), 32'd255);

      // clr_count coincident with a fall_pulse keeps the event
      e = cyc;
      pin0 = 1'b0;
      pulse_q.push_back(e + int'(LAT0));
      step(6);
      bus0.clr_count = 1'b1;
      step(1);
      bus0.clr_count = 1'b0;
      check("clr_coinc_count", 32'(bus0.event_count), 32'd1);
      pin0 = 1'b1;
      step(12);
      bus0.clr_count = 1'b1;
      step(1);
      bus0.clr_count = 1'b0;
      check("clr_count_alone", 32'(bus0.event_count), 32'd0);

      // DEBOUNCE_CYCLES=1 rising acceptance: no pulse, capture unchanged
      pin1 = 1'b1;
      step(2);
      check("d1_level_e2", 32'(bus1.int_level_n), 32'd0);
      step(1);
      check("d1_level_e3", 32'(bus1.int_level_n), 32'd1);
      check("d1_fall_e3",  32'(bus1.fall_pulse),  32'd0);
      step(1);
      check("d1_fall_e4",    32'(bus1.fall_pulse), 32'd0);
      check("d1_capture_e4", 32'(bus1.capture),    32'd1);

      step(5);
      check("pending_pulses", 32'(pulse_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
